truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Parametrised, self-checking exhaustive stimulus engine for combinational lab circuits with N_IN inputs and N_OUT outputs.
- On start, drives every input combination 0 .. 2^N_IN-1 in ascending order, holding each one for DWELL cycles.
- Compares the DUT outputs against a golden-model output at the end of each hold and accumulates pass/fail results.
- Sits between a DUT and its golden reference model.
- Replaces the hand-written vector lists in the lab benches with a synthesizable, cycle-accurate sweeper.

Parameters:
N_IN, 4, number of DUT inputs; sweep length is 2^N_IN vectors; legal range 1..16
N_OUT, 2, number of DUT outputs compared; legal range 1..32
DWELL, 20, cycles each vector is held; must be >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep; sampled only when busy=0
abort  input  1  terminate a running sweep; ignored when busy=0
dut_out  input  N_OUT  DUT outputs; combinational function of stim
exp_out  input  N_OUT  golden-model outputs; combinational function of stim
stim  output  N_IN  current input vector driven to DUT and golden model
busy  output  1  sweep in progress
done  output  1  sweep completed; held until the next start or rst
pass  output  1  valid when done=1; 1 iff err_count==0
err_count  output  N_IN+1  number of mismatching vectors
first_err_vec  output  N_IN  stim value of the first mismatch; 0 if none
fail_mask  output  N_OUT  sticky OR of (dut_out ^ exp_out) over all compares

Behaviour:
- One clock. Reset is synchronous and active-high. All state is registered.
- rst=1 at any edge, including mid-sweep, forces on the following cycle: state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, fail_mask=0, dwell_cnt=0.
- rst has priority over start and abort.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge k:
  - state<=RUN, busy<=1, done<=0, pass<=0.
  - stim<=0, dwell_cnt<=0.
  - err_count, first_err_vec and fail_mask cleared.
- RUN, start=1 is ignored.
- RUN, per edge, when dwell_cnt != DWELL-1: dwell_cnt++ and nothing else changes.
- RUN, per edge, when dwell_cnt == DWELL-1 (compare edge):
  - Compare the dut_out and exp_out values present before the edge.
  - On mismatch: err_count++; fail_mask |= dut_out^exp_out; if this is the first mismatch, first_err_vec<=stim.
  - dwell_cnt<=0.
  - If stim == all-ones: state<=DONE, busy<=0, done<=1, pass<=(final err_count==0). The final count includes this compare.
  - Otherwise stim<=stim+1.
- Timing:
  - Vector v is driven from edge k+v*DWELL and compared at edge k+(v+1)*DWELL.
  - done rises at edge k+2^N_IN*DWELL.
  - The DUT and golden model must settle within one cycle; DWELL=1 is legal.
- err_count width N_IN+1 holds 2^N_IN exactly. No saturation or overflow is possible.
- stim never wraps during a sweep. The increment past all-ones does not occur.
- abort=1 in RUN (rst=0):
  - Next state IDLE, busy<=0, done<=0, pass<=0, stim<=0, dwell_cnt<=0.
  - err_count, first_err_vec and fail_mask hold their partial values.
- abort on a compare edge: abort wins, and that compare is discarded.
- start and abort together in IDLE/DONE: start wins, because abort is ignored when not busy.
- DONE: all outputs hold and stim stays at all-ones until start or rst.

Decomposition:
- Shared include (truth_table_defs.vh): FSM state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and a clog2 helper function for the dwell_cnt width.
- One sub-module, dwell_timer:
  - Parameter DWELL; ports clk, rst, clr, en, tick.
  - Mod-DWELL counter; tick=1 when count==DWELL-1 and en=1.
- The top-level FSM uses tick as the compare strobe.

Test Plan:
1. N_IN=4, N_OUT=2, DWELL=20, dut_out=exp_out=f(stim), start pulsed at cycle 0 -> stim steps 0..15, each held exactly 20 cycles; done=1 and busy=0 at cycle 320; pass=1, err_count=0, fail_mask=2'b00.
2. Same setup, dut_out[0] inverted only when stim==5 -> err_count=1, first_err_vec=4'd5, fail_mask=2'b01, pass=0.
3. exp_out=stim[1:0], dut_out stuck at 2'b00 -> err_count=12, first_err_vec=4'd1, fail_mask=2'b11, pass=0.
4. abort at cycle 100 (stim=5) -> at cycle 101 busy=0, done=0, stim=0; a new start then runs a full clean sweep (done exactly 320 cycles after that start, pass=1).
5. rst at cycle 50 -> next cycle all outputs at reset values; start re-pulsed at cycle 60 while a second start pulse at cycle 70 is ignored -> done at cycle 380.
6. DWELL=1, N_IN=3 -> stim changes every cycle 0..7; done asserted exactly 8 cycles after start; single mismatch at stim==7 gives first_err_vec=3'd7, err_count=1.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper.
//   state_t : FSM state encodings (IDLE=0, RUN=1, DONE=2)
//   cnt_w() : counter width for a mod-n counter, never narrower than 1 bit
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width needed to hold 0..n-1; at least 1 so DWELL=1 still gets a real register.
    function automatic int cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_dwell_timer.sv
// Mod-DWELL hold counter for the sweeper.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (count -> 0)
//   clr  : synchronous clear (count -> 0), wins over en
//   en   : count enable
//   tick : high while en=1 and the count sits on its last value (DWELL-1)
module dwell_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int DWELL = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CW   = cnt_w(DWELL);
    localparam logic [CW-1:0]  LAST = CW'(DWELL - 1);

    logic [CW-1:0] dwell_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            dwell_cnt <= '0;
        else if (en)
            dwell_cnt <= (dwell_cnt == LAST) ? '0 : dwell_cnt + CW'(1);
    end

    assign tick = en && (dwell_cnt == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives stim 0..2^N_IN-1, holds each vector
// DWELL cycles, compares dut_out against exp_out at the end of each hold.
//   clk, rst       : clock, synchronous active-high reset
//   start, abort   : begin a sweep (when not busy) / stop a running sweep
//   dut_out        : DUT outputs        exp_out : golden outputs
//   stim           : current vector     busy/done/pass : sweep status
//   err_count      : mismatching vectors
//   first_err_vec  : stim of first mismatch (0 if none)
//   fail_mask      : sticky OR of dut_out ^ exp_out
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int DWELL = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] dut_out,
    input  logic [N_OUT-1:0] exp_out,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_err_vec,
    output logic [N_OUT-1:0] fail_mask
);

    state_t           state, nxt_state;
    logic [N_IN-1:0]  nxt_stim, nxt_first;
    logic [N_IN:0]    nxt_err;
    logic [N_OUT-1:0] nxt_mask;
    logic             nxt_pass;
    logic             tick, timer_clr, mismatch;

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (state == ST_RUN),
        .tick (tick)
    );

    assign mismatch = (dut_out != exp_out);
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            stim          <= '0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
            fail_mask     <= '0;
        end else begin
            state         <= nxt_state;
            stim          <= nxt_stim;
            pass          <= nxt_pass;
            err_count     <= nxt_err;
            first_err_vec <= nxt_first;
            fail_mask     <= nxt_mask;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_stim  = stim;
        nxt_pass  = pass;
        nxt_err   = err_count;
        nxt_first = first_err_vec;
        nxt_mask  = fail_mask;
        timer_clr = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                // abort is meaningless here, so start always wins
                if (start) begin
                    nxt_state = ST_RUN;
                    nxt_stim  = '0;
                    nxt_pass  = 1'b0;
                    nxt_err   = '0;
                    nxt_first = '0;
                    nxt_mask  = '0;
                    timer_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // statistics keep their partial values; a compare on this edge is dropped
                    nxt_state = ST_IDLE;
                    nxt_stim  = '0;
                    nxt_pass  = 1'b0;
                    timer_clr = 1'b1;
                end else if (tick) begin
                    if (mismatch) begin
                        nxt_err  = err_count + (N_IN+1)'(1);
                        nxt_mask = fail_mask | (dut_out ^ exp_out);
                        if (err_count == '0)
                            nxt_first = stim;
                    end
                    if (stim == '1) begin
                        nxt_state = ST_DONE;
                        nxt_pass  = (nxt_err == '0);
                    end else begin
                        nxt_stim = stim + N_IN'(1);
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: N_IN=4, N_OUT=2, DWELL=20
    logic       rst, start_a, abort_a;
    logic [1:0] dut_a, exp_a, mask_a;
    logic [3:0] stim_a, first_a;
    logic [4:0] err_a;
    logic       busy_a, done_a, pass_a;
    int         mode;

    // instance B: N_IN=3, N_OUT=2, DWELL=1
    logic       start_b;
    logic [1:0] dut_b, exp_b, mask_b;
    logic [2:0] stim_b, first_b;
    logic [3:0] err_b;
    logic       busy_b, done_b, pass_b;

    int nchk  = 0;
    int nfail = 0;

    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .DWELL(20)) dut_a_i (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .dut_out(dut_a), .exp_out(exp_a), .stim(stim_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_err_vec(first_a), .fail_mask(mask_a)
    );

    truth_table_sweeper #(.N_IN(3), .N_OUT(2), .DWELL(1)) dut_b_i (
        .clk(clk), .rst(rst), .start(start_b), .abort(1'b0),
        .dut_out(dut_b), .exp_out(exp_b), .stim(stim_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_err_vec(first_b), .fail_mask(mask_b)
    );

    // Lab circuit models driven by stim
    always_comb begin
        exp_a = {stim_a[3] ^ stim_a[0], stim_a[1] & stim_a[2]};
        dut_a = exp_a;
        if (mode == 1 && stim_a == 4'd5) dut_a = exp_a ^ 2'b01;
        if (mode == 2) begin
            exp_a = stim_a[1:0];
            dut_a = 2'b00;
        end
        exp_b = stim_b[1:0];
        dut_b = (stim_b == 3'd7) ? exp_b ^ 2'b10 : exp_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
    endtask

    // Cycles from the start edge until done, bounded
    task automatic wait_done_a(input string tag, input int expected);
        int n;
        n = 0;
        while (!done_a && n < expected + 50) begin
            step(1);
            n++;
        end
        chk(tag, n, expected);
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, " stim"},  stim_a,  0);
        chk({tag, " busy"},  busy_a,  0);
        chk({tag, " done"},  done_a,  0);
        chk({tag, " pass"},  pass_a,  0);
        chk({tag, " err"},   err_a,   0);
        chk({tag, " first"}, first_a, 0);
        chk({tag, " mask"},  mask_a,  0);
    endtask

    task automatic chk_result_a(input string tag, input int e, input int f,
                                input int m, input int p);
        chk({tag, " done"},  done_a,  1);
        chk({tag, " busy"},  busy_a,  0);
        chk({tag, " pass"},  pass_a,  p);
        chk({tag, " err"},   err_a,   e);
        chk({tag, " first"}, first_a, f);
        chk({tag, " mask"},  mask_a,  m);
        chk({tag, " stim"},  stim_a,  15);
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; mode = 0;
        step(3);
        rst = 1'b0;
        chk_idle_reset("reset");

        // 1: clean sweep, check every hold window
        pulse_start_a();
        for (int v = 0; v < 16; v++) begin
            chk("t1 hold start", stim_a, v);
            chk("t1 busy", busy_a, 1);
            step(19);
            chk("t1 hold end", stim_a, v);
            chk("t1 not done", done_a, 0);
            step(1);
        end
        chk_result_a("t1", 0, 0, 0, 1);
        step(7);
        chk("t1 hold in DONE", stim_a, 15);
        chk("t1 done held", done_a, 1);

        // 2: single bit-0 error at stim 5
        mode = 1;
        pulse_start_a();
        chk("t2 busy", busy_a, 1);
        chk("t2 done cleared", done_a, 0);
        chk("t2 err cleared", err_a, 0);
        wait_done_a("t2 latency", 320);
        chk_result_a("t2", 1, 5, 1, 0);

        // 3: stuck-at-zero DUT against stim[1:0]
        mode = 2;
        pulse_start_a();
        wait_done_a("t3 latency", 320);
        chk_result_a("t3", 12, 1, 3, 0);

        // start together with abort from DONE: start wins and clears stats
        start_a = 1'b1; abort_a = 1'b1;
        step(1);
        start_a = 1'b0; abort_a = 1'b0;
        chk("start+abort busy", busy_a, 1);
        chk("start+abort err", err_a, 0);
        chk("start+abort mask", mask_a, 0);

        // abort sampled on the compare edge of stim 3 (a mismatch): discarded
        step(79);
        chk("t4b stim before abort", stim_a, 3);
        abort_a = 1'b1;
        step(1);
        abort_a = 1'b0;
        chk("t4b busy", busy_a, 0);
        chk("t4b stim", stim_a, 0);
        chk("t4b err partial", err_a, 2);
        chk("t4b first partial", first_a, 1);
        chk("t4b mask partial", mask_a, 3);
        step(5);
        chk("t4b idle holds", busy_a, 0);

        // 4: abort at cycle 100, then a full clean sweep
        mode = 0;
        pulse_start_a();
        step(100);
        chk("t4 stim at 100", stim_a, 5);
        abort_a = 1'b1;
        step(1);
        abort_a = 1'b0;
        chk("t4 busy", busy_a, 0);
        chk("t4 done", done_a, 0);
        chk("t4 stim", stim_a, 0);
        pulse_start_a();
        wait_done_a("t4 latency", 320);
        chk_result_a("t4", 0, 0, 0, 1);

        // 5: rst mid-sweep, restart at 60, ignored start at 70
        mode = 1;
        pulse_start_a();
        step(49);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_idle_reset("t5 reset");
        step(9);
        pulse_start_a();
        step(9);
        chk("t5 stim before 2nd start", stim_a, 0);
        pulse_start_a();
        chk("t5 2nd start ignored", stim_a, 0);
        wait_done_a("t5 latency", 310);
        chk_result_a("t5", 1, 5, 1, 0);

        // 6: DWELL=1, N_IN=3
        chk("t6 idle", busy_b, 0);
        start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        for (int v = 0; v < 8; v++) begin
            chk("t6 stim", stim_b, v);
            chk("t6 not done", done_b, 0);
            step(1);
        end
        chk("t6 done", done_b, 1);
        chk("t6 busy", busy_b, 0);
        chk("t6 err", err_b, 1);
        chk("t6 first", first_b, 7);
        chk("t6 mask", mask_b, 2);
        chk("t6 pass", pass_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
